// File: rtl/mux_pkg.sv
// Shared definitions for the N:1 stream multiplexer.
// Select modes, skid-buffer occupancy encoding and a width helper.
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Occupancy of the 2-entry output skid buffer.
  typedef enum logic [1:0] {
    CNT_EMPTY = 2'd0,
    CNT_ONE   = 2'd1,
    CNT_FULL  = 2'd2
  } buf_cnt_e;

  // ceil(log2(n)), but never below 1 so index vectors always have a bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requesting channel
// found by scanning upward from ptr+1 and wrapping past NUM_IN-1 to 0.
module mux_rr_arbiter
  import mux_pkg::*;
#(
  parameter int NUM_IN = 16,
  parameter int SEL_W  = clog2_min1(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [SEL_W-1:0]  grant_idx,
  output logic              grant_vld
);

  int idx;

  // Rotating priority scan; the last granted channel has lowest priority.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    grant_idx = '0;
    grant_vld = 1'b0;
    idx       = 0;
    for (int k = 1; k <= NUM_IN; k++) begin
      idx = (int'(ptr) + k) % NUM_IN;
      if (!grant_vld && req[idx]) begin
        grant_vld = 1'b1;
        grant_idx = SEL_W'(idx);
      end
    end
  end

endmodule

// File: rtl/mux_n_to_1_stream.sv
// N-input, W-bit stream multiplexer with valid/ready handshakes, fixed or
// round-robin source selection and a registered 2-entry output skid buffer.
// Optional feature: MUX_SEL_RANGE_CHECK_EN adds a sticky err_sel output and
// refuses out-of-range fixed selects instead of clamping them.
module mux_n_to_1_stream
  import mux_pkg::*;
#(
  parameter int NUM_IN = 16,
  parameter int DATA_W = 32,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         sel,
  input  logic [NUM_IN-1:0]        in_valid,
  input  logic [NUM_IN*DATA_W-1:0] in_data,
  output logic [NUM_IN-1:0]        in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_src,
  input  logic                     out_ready
`ifdef MUX_SEL_RANGE_CHECK_EN
  ,
  output logic                     err_sel
`endif
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [SEL_W-1:0]  src;
  } entry_t;

  // Skid buffer: head_q is what out_* shows, tail_q only holds data while full.
  entry_t     head_q, head_d;
  entry_t     tail_q, tail_d;
  buf_cnt_e   count_q, count_d;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

  logic [SEL_W-1:0] arb_idx;
  logic             arb_vld;
  logic [SEL_W-1:0] fix_idx;
  logic             fix_vld;
  logic             sel_oor;
  logic [SEL_W-1:0] grant_idx;
  logic             grant_vld;
  logic             push;
  logic             pop;
  entry_t           new_entry;

  mux_rr_arbiter #(
    .NUM_IN (NUM_IN),
    .SEL_W  (SEL_W)
  ) u_arb (
    .req       (in_valid),
    .ptr       (rr_ptr_q),
    .grant_idx (arb_idx),
    .grant_vld (arb_vld)
  );

  // Fixed-mode grant, including handling of selects beyond the last channel.
  always_comb begin
    sel_oor = (32'(sel) >= 32'(NUM_IN));
`ifdef MUX_SEL_RANGE_CHECK_EN
    fix_idx = sel;
    fix_vld = !sel_oor && in_valid[sel];
`else
    fix_idx = sel_oor ? SEL_W'(NUM_IN - 1) : sel;
    fix_vld = in_valid[fix_idx];
`endif
  end

  // Final grant, handshake and the entry that would be pushed this cycle.
  always_comb begin
    grant_idx = (mode == MODE_RR) ? arb_idx : fix_idx;
    grant_vld = (mode == MODE_RR) ? arb_vld : fix_vld;
    // Readiness comes from registered occupancy only, never from out_ready.
    push      = grant_vld && (count_q != CNT_FULL);
    pop       = (count_q != CNT_EMPTY) && out_ready;
    in_ready  = '0;
    if (push) in_ready[grant_idx] = 1'b1;
    new_entry.data = in_data[int'(grant_idx)*DATA_W +: DATA_W];
    new_entry.src  = grant_idx;
  end

  // Next-state of the skid buffer and round-robin pointer.
  always_comb begin
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    rr_ptr_d = rr_ptr_q;
    if (push) rr_ptr_d = grant_idx;
    unique case (count_q)
      CNT_EMPTY: begin
        if (push) begin
          head_d  = new_entry;
          count_d = CNT_ONE;
        end
      end
      CNT_ONE: begin
        if (push && pop) begin
          head_d = new_entry;
        end else if (push) begin
          tail_d  = new_entry;
          count_d = CNT_FULL;
        end else if (pop) begin
          count_d = CNT_EMPTY;
        end
      end
      CNT_FULL: begin
        if (pop) begin
          head_d  = tail_q;
          count_d = CNT_ONE;
        end
      end
      default: count_d = CNT_EMPTY;
    endcase
  end

  // State registers; the two buffer slots are plain registers so they reset too.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= CNT_EMPTY;
      rr_ptr_q <= SEL_W'(NUM_IN - 1);
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Output view of the buffer head; data holds its last value when empty.
  always_comb begin
    out_valid = (count_q != CNT_EMPTY);
    out_data  = head_q.data;
    out_src   = head_q.src;
  end

`ifdef MUX_SEL_RANGE_CHECK_EN
  logic err_sel_q, err_sel_d;

  // Sticky flag: any fixed-mode select past the last channel.
  always_comb begin
    err_sel_d = err_sel_q | ((mode == MODE_FIXED) && sel_oor);
  end

  // Error flag register, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) err_sel_q <= 1'b0;
    else     err_sel_q <= err_sel_d;
  end

  assign err_sel = err_sel_q;
`endif

endmodule

// File: tb/tb_mux_n_to_1_stream.sv
// Self-checking bench for mux_n_to_1_stream: scoreboard model plus directed
// vectors and hand-written sequences for backpressure, fairness and reset.
module tb_mux_n_to_1_stream;

  localparam int N = 16;
  localparam int W = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            mode;
  logic [3:0]      sel;
  logic [N-1:0]    in_valid;
  logic [N*W-1:0]  in_data;
  logic [N-1:0]    in_ready;
  logic            out_valid;
  logic [W-1:0]    out_data;
  logic [3:0]      out_src;
  logic            out_ready;

  // 12-channel instance for the non-power-of-two select case.
  logic            mode12;
  logic [3:0]      sel12;
  logic [11:0]     in_valid12;
  logic [12*W-1:0] in_data12;
  logic [11:0]     in_ready12;
  logic            out_valid12;
  logic [W-1:0]    out_data12;
  logic [3:0]      out_src12;
  logic            out_ready12;
`ifdef MUX_SEL_RANGE_CHECK_EN
  logic            err_sel;
  logic            err_sel12;
`endif

  always #5 clk = ~clk;

  mux_n_to_1_stream #(.NUM_IN(N), .DATA_W(W)) u_dut (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
    .out_ready(out_ready)
`ifdef MUX_SEL_RANGE_CHECK_EN
    , .err_sel(err_sel)
`endif
  );

  mux_n_to_1_stream #(.NUM_IN(12), .DATA_W(W)) u_dut12 (
    .clk(clk), .rst(rst), .mode(mode12), .sel(sel12),
    .in_valid(in_valid12), .in_data(in_data12), .in_ready(in_ready12),
    .out_valid(out_valid12), .out_data(out_data12), .out_src(out_src12),
    .out_ready(out_ready12)
`ifdef MUX_SEL_RANGE_CHECK_EN
    , .err_sel(err_sel12)
`endif
  );

  typedef struct packed {
    logic [W-1:0] data;
    logic [3:0]   src;
  } ent_t;

  ent_t       sb[$];
  ent_t       last_push;
  logic [3:0] m_ptr;
  int         n_checks = 0;
  int         n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference grant: FIXED uses sel directly, RR walks a 4-bit wrapping index.
  task automatic model_grant(output logic vld, output logic [3:0] idx);
    vld = 1'b0;
    idx = '0;
    if (mode == 1'b0) begin
      vld = in_valid[sel];
      idx = sel;
    end else begin
      for (int k = 1; k <= N; k++) begin
        logic [3:0] c;
        c = m_ptr + 4'(k);
        if (!vld && in_valid[c]) begin
          vld = 1'b1;
          idx = c;
        end
      end
    end
  endtask

  // One clock of the main DUT, checked against the scoreboard; starts and ends just after negedge.
  task automatic cycle();
    logic       g_vld, do_push, do_pop;
    logic [3:0] g;
    logic [N-1:0] exp_rdy;
    ent_t       e;
    #1;
    model_grant(g_vld, g);
    do_push = g_vld && (sb.size() < 2);
    exp_rdy = do_push ? (N'(1) << g) : '0;
    check("in_ready", 64'(in_ready), 64'(exp_rdy));
    check("out_valid", 64'(out_valid), 64'(sb.size() != 0));
    if (sb.size() != 0) begin
      check("out_data", 64'(out_data), 64'(sb[0].data));
      check("out_src", 64'(out_src), 64'(sb[0].src));
    end
    do_pop = (sb.size() != 0) && out_ready;
    e.data = in_data[int'(g)*W +: W];
    e.src  = g;
    @(posedge clk);
    if (do_pop) void'(sb.pop_front());
    if (do_push) begin
      sb.push_back(e);
      last_push = e;
      m_ptr = g;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = '0;
    @(posedge clk);
    sb.delete();
    m_ptr = 4'(N - 1);
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [3:0]   sel;
    logic [N-1:0] valid;
    logic [N-1:0] exp_ready;
    logic         exp_out;
    logic [3:0]   exp_src;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{sel: 4'd0,  valid: 16'h0001, exp_ready: 16'h0001, exp_out: 1'b1, exp_src: 4'd0};
    vecs[1] = '{sel: 4'd7,  valid: 16'hFF7F, exp_ready: 16'h0000, exp_out: 1'b0, exp_src: 4'd0};
    vecs[2] = '{sel: 4'd15, valid: 16'h8000, exp_ready: 16'h8000, exp_out: 1'b1, exp_src: 4'd15};
    vecs[3] = '{sel: 4'd9,  valid: 16'hFFFF, exp_ready: 16'h0200, exp_out: 1'b1, exp_src: 4'd9};
    vecs[4] = '{sel: 4'd2,  valid: 16'h0000, exp_ready: 16'h0000, exp_out: 1'b0, exp_src: 4'd0};
    vecs[5] = '{sel: 4'd12, valid: 16'h1000, exp_ready: 16'h1000, exp_out: 1'b1, exp_src: 4'd12};

    rst = 1'b1; mode = 1'b0; sel = '0; in_valid = '0; in_data = '0; out_ready = 1'b1;
    mode12 = 1'b0; sel12 = '0; in_valid12 = '0; in_data12 = '0; out_ready12 = 1'b1;
    m_ptr = 4'(N - 1);
    last_push = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state.
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_src", 64'(out_src), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);

    // Fixed select of channel 5, one-cycle latency.
    mode = 1'b0; sel = 4'd5; in_valid = 16'h0020;
    in_data[5*W +: W] = 32'hA5A5_0005;
    #1 check("t1_in_ready", 64'(in_ready), 64'h0020);
    cycle();
    in_valid = '0;
    #1;
    check("t1_out_valid", 64'(out_valid), 64'd1);
    check("t1_out_data", 64'(out_data), 64'hA5A5_0005);
    check("t1_out_src", 64'(out_src), 64'd5);
    cycle();

    // Fixed-mode vector table with the consumer always ready.
    for (int v = 0; v < 6; v++) begin
      sel = vecs[v].sel;
      in_valid = vecs[v].valid;
      for (int i = 0; i < N; i++) in_data[i*W +: W] = {8'(v), 8'h5A, 16'(i)};
      #1 check("vec_in_ready", 64'(in_ready), 64'(vecs[v].exp_ready));
      cycle();
      #1 check("vec_out_valid", 64'(out_valid), 64'(vecs[v].exp_out));
      if (vecs[v].exp_out) check("vec_out_src", 64'(out_src), 64'(vecs[v].exp_src));
    end
    in_valid = '0;
    cycle();

    // Round robin over all channels: no bubbles, sources in order.
    do_reset();
    mode = 1'b1; in_valid = '1; out_ready = 1'b1;
    for (int i = 0; i < N; i++) in_data[i*W +: W] = 32'(i);
    for (int k = 0; k < 32; k++) begin
      cycle();
      #1;
      check("t2_out_valid", 64'(out_valid), 64'd1);
      check("t2_out_src", 64'(out_src), 64'(k % N));
      check("t2_out_data", 64'(out_data), 64'(k % N));
    end
    in_valid = '0;
    repeat (2) cycle();

    // Backpressure on channel 3: buffer fills, output freezes, then drains in order.
    do_reset();
    mode = 1'b0; sel = 4'd3; in_valid = 16'h0008; out_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      in_data[3*W +: W] = 32'hC0DE_0000 + 32'(c);
      if (c == 4) out_ready = 1'b1;
      if (c == 2 || c == 3) begin
        #1;
        check("t3_full_in_ready", 64'(in_ready), 64'd0);
        check("t3_frozen_data", 64'(out_data), 64'hC0DE_0000);
      end
      cycle();
    end
    in_valid = '0;
    repeat (3) cycle();
    #1;
    check("t3_empty_valid", 64'(out_valid), 64'd0);
    check("t3_hold_data", 64'(out_data), 64'(last_push.data));

    // Fair alternation between channels 0 and 15.
    do_reset();
    mode = 1'b1; in_valid = 16'h8001; out_ready = 1'b1;
    for (int i = 0; i < N; i++) in_data[i*W +: W] = 32'h4000_0000 + 32'(i);
    cycle();
    for (int k = 0; k < 4; k++) begin
      #1 check("t4_grant", 64'(in_ready), (k % 2 == 0) ? 64'h8000 : 64'h0001);
      cycle();
    end
    in_valid = '0;
    repeat (2) cycle();

    // Reset while the buffer is full.
    do_reset();
    mode = 1'b0; sel = 4'd3; in_valid = 16'h0008; out_ready = 1'b0;
    repeat (2) cycle();
    #1 check("t5_full", 64'(in_ready), 64'd0);
    do_reset();
    #1;
    check("t5_out_valid", 64'(out_valid), 64'd0);
    check("t5_in_ready", 64'(in_ready), 64'd0);
    mode = 1'b1; in_valid = 16'h0110; out_ready = 1'b1;
    #1 check("t5_first_rr", 64'(in_ready), 64'h0010);
    cycle();
    in_valid = '0;
    repeat (2) cycle();

    // 12-channel instance with an out-of-range fixed select.
    mode12 = 1'b0; sel12 = 4'd13; in_valid12 = 12'hFFF; out_ready12 = 1'b1;
    for (int i = 0; i < 12; i++) in_data12[i*W +: W] = 32'h1200_0000 + 32'(i);
    #1;
`ifdef MUX_SEL_RANGE_CHECK_EN
    check("t6_in_ready", 64'(in_ready12), 64'd0);
    @(posedge clk); @(negedge clk); #1;
    check("t6_out_valid", 64'(out_valid12), 64'd0);
    check("t6_err_sel", 64'(err_sel12), 64'd1);
    sel12 = 4'd2;
    @(posedge clk); @(negedge clk); #1;
    check("t6_err_sticky", 64'(err_sel12), 64'd1);
`else
    check("t6_in_ready", 64'(in_ready12), 64'h800);
    @(posedge clk); @(negedge clk); #1;
    check("t6_out_valid", 64'(out_valid12), 64'd1);
    check("t6_out_src", 64'(out_src12), 64'd11);
    check("t6_out_data", 64'(out_data12), 64'h1200_000B);
`endif
    in_valid12 = '0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
